// File: rtl/ahb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_pkg
// Shared AHB-Lite definitions for the response multiplexer slice:
//   - HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ)
//   - HRESP encodings (OKAY, ERROR)
//   - default-subordinate FSM state enum
//   - data-phase owner enum
//   - helper that classifies an HTRANS value as a real transfer
// ---------------------------------------------------------------------------
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_e;

  typedef enum logic [1:0] {
    OWN_NONE    = 2'b00,
    OWN_SUB     = 2'b01,
    OWN_DEFAULT = 2'b10
  } owner_e;

  // NONSEQ and SEQ carry a transfer that must be answered; IDLE and BUSY do not.
  function automatic logic is_active_trans(input logic [1:0] trans);
    logic active;
    case (trans)
      HTRANS_NONSEQ, HTRANS_SEQ: active = 1'b1;
      HTRANS_IDLE, HTRANS_BUSY:  active = 1'b0;
      default:                   active = 1'b0;
    endcase
    return active;
  endfunction

endpackage

// File: rtl/ahb_default_sub.sv
// ---------------------------------------------------------------------------
// ahb_default_sub
// Built-in default subordinate. Answers a decode error with the two-cycle
// AHB ERROR response (ERR1: HREADY=0, ERR2: HREADY=1, both HRESP=ERROR).
// Ports:
//   HCLK, HRESETn : clock, asynchronous active-low reset
//   accept        : address phase accepted this edge (muxed HREADY)
//   hit           : the address phase on the bus is a decode error
//   hready, hresp : data-phase response while this block owns the phase
//   dec_err       : high for exactly the ERR1 cycle
// ---------------------------------------------------------------------------
module ahb_default_sub
  import ahb_pkg::*;
(
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       accept,
  input  logic       hit,
  output logic       hready,
  output logic [1:0] hresp,
  output logic       dec_err
);

  ds_state_e state_r;
  ds_state_e state_nxt_s;

  // Next-state logic for the two-cycle error response.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      DS_IDLE: begin
        if (accept && hit) begin
          state_nxt_s = DS_ERR1;
        end else begin
          state_nxt_s = DS_IDLE;
        end
      end
      // ERR1 holds HREADY low, so nothing is accepted here.
      DS_ERR1: state_nxt_s = DS_ERR2;
      DS_ERR2: begin
        if (accept) begin
          if (hit) begin
            state_nxt_s = DS_ERR1;
          end else begin
            state_nxt_s = DS_IDLE;
          end
        end else begin
          state_nxt_s = DS_ERR2;
        end
      end
      default: state_nxt_s = DS_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_r <= DS_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Response outputs decoded from the state register only (no input paths).
  always_comb begin
    hready  = 1'b1;
    hresp   = HRESP_OKAY;
    dec_err = 1'b0;
    case (state_r)
      DS_IDLE: begin
        hready  = 1'b1;
        hresp   = HRESP_OKAY;
        dec_err = 1'b0;
      end
      DS_ERR1: begin
        hready  = 1'b0;
        hresp   = HRESP_ERROR;
        dec_err = 1'b1;
      end
      DS_ERR2: begin
        hready  = 1'b1;
        hresp   = HRESP_ERROR;
        dec_err = 1'b0;
      end
      default: begin
        hready  = 1'b1;
        hresp   = HRESP_OKAY;
        dec_err = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ahb_resp_mux_n.sv
// ---------------------------------------------------------------------------
// ahb_resp_mux_n
// AHB-Lite data-phase response multiplexer for N subordinates. Registers the
// data-phase owner on each accepted address phase and routes that owner's
// HRDATA/HRESP/HREADYOUT to the manager. Unmapped or multiply-selected real
// transfers go to the built-in default subordinate; a saturating counter
// tracks how many decode errors occurred.
// Ports:
//   HCLK, HRESETn  : clock, asynchronous active-low reset
//   HSEL[N]        : address-phase select vector from the decoder
//   HTRANS[2]      : address-phase transfer type
//   HREADYOUT_S[N] : per-subordinate ready
//   HRESP_S[2N]    : per-subordinate response, bits [2i+1:2i]
//   HRDATA_S[N*DW] : per-subordinate read data, slice i
//   HRDATA, HRESP, HREADY : muxed response to the manager
//   dec_err        : one-cycle pulse during ERR1
//   dec_err_cnt    : saturating decode-error count
// ---------------------------------------------------------------------------
module ahb_resp_mux_n
  import ahb_pkg::*;
#(
  parameter int DATA_WIDTH         = 32,
  parameter int NO_OF_SUBORDINATES = 4,
  parameter int ERR_CNT_WIDTH      = 8
) (
  input  logic                                     HCLK,
  input  logic                                     HRESETn,
  input  logic [NO_OF_SUBORDINATES-1:0]            HSEL,
  input  logic [1:0]                               HTRANS,
  input  logic [NO_OF_SUBORDINATES-1:0]            HREADYOUT_S,
  input  logic [2*NO_OF_SUBORDINATES-1:0]          HRESP_S,
  input  logic [NO_OF_SUBORDINATES*DATA_WIDTH-1:0] HRDATA_S,
  output logic [DATA_WIDTH-1:0]                    HRDATA,
  output logic [1:0]                               HRESP,
  output logic                                     HREADY,
  output logic                                     dec_err,
  output logic [ERR_CNT_WIDTH-1:0]                 dec_err_cnt
);

  localparam int N     = NO_OF_SUBORDINATES;
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1;

  logic [4:0]            hot_cnt_s;
  logic [SEL_W-1:0]      hot_idx_s;
  logic                  onehot_s;
  logic                  decode_err_s;

  owner_e                owner_r;
  logic [SEL_W-1:0]      data_sel_r;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_r;

  logic                  def_hready_s;
  logic [1:0]            def_hresp_s;
  logic                  def_dec_err_s;

  logic [DATA_WIDTH-1:0] hrdata_s;
  logic [1:0]            hresp_s;
  logic                  hready_s;

  // Count selected bits and remember the selected index for the one-hot case.
  always_comb begin
    hot_cnt_s = 5'd0;
    hot_idx_s = '0;
    for (int i = 0; i < N; i++) begin
      hot_cnt_s = hot_cnt_s + 5'(HSEL[i]);
      if (HSEL[i]) begin
        hot_idx_s = SEL_W'(i);
      end else begin
        hot_idx_s = hot_idx_s;
      end
    end
  end

  assign onehot_s     = (hot_cnt_s == 5'd1);
  assign decode_err_s = !onehot_s && is_active_trans(HTRANS);

  // Data-phase owner register; only updates on an accepted address phase,
  // so HSEL/HTRANS wiggles during wait states are ignored.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      owner_r    <= OWN_NONE;
      data_sel_r <= '0;
    end else if (hready_s) begin
      if (onehot_s) begin
        owner_r    <= OWN_SUB;
        data_sel_r <= hot_idx_s;
      end else if (decode_err_s) begin
        owner_r    <= OWN_DEFAULT;
      end else begin
        owner_r    <= OWN_NONE;
      end
    end
  end

  // Saturating decode-error counter, bumped on the edge that enters ERR1.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      err_cnt_r <= '0;
    end else if (hready_s && decode_err_s && !(&err_cnt_r)) begin
      err_cnt_r <= err_cnt_r + ERR_CNT_WIDTH'(1);
    end
  end

  ahb_default_sub u_default_sub (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .accept  (hready_s),
    .hit     (decode_err_s),
    .hready  (def_hready_s),
    .hresp   (def_hresp_s),
    .dec_err (def_dec_err_s)
  );

  // Response mux. HREADY depends only on the owner register and the owner's
  // ready, so using it as the accept strobe creates no combinational loop.
  always_comb begin
    hrdata_s = '0;
    hresp_s  = HRESP_OKAY;
    hready_s = 1'b1;
    case (owner_r)
      OWN_SUB: begin
        for (int i = 0; i < N; i++) begin
          if (data_sel_r == SEL_W'(i)) begin
            hrdata_s = HRDATA_S[i*DATA_WIDTH +: DATA_WIDTH];
            hresp_s  = HRESP_S[2*i +: 2];
            hready_s = HREADYOUT_S[i];
          end else begin
            hrdata_s = hrdata_s;
          end
        end
      end
      OWN_DEFAULT: begin
        hrdata_s = '0;
        hresp_s  = def_hresp_s;
        hready_s = def_hready_s;
      end
      OWN_NONE: begin
        hrdata_s = '0;
        hresp_s  = HRESP_OKAY;
        hready_s = 1'b1;
      end
      default: begin
        hrdata_s = '0;
        hresp_s  = HRESP_OKAY;
        hready_s = 1'b1;
      end
    endcase
  end

  assign HRDATA      = hrdata_s;
  assign HRESP       = hresp_s;
  assign HREADY      = hready_s;
  assign dec_err     = def_dec_err_s;
  assign dec_err_cnt = err_cnt_r;

endmodule

// File: tb/tb_ahb_resp_mux_n.sv
module tb_ahb_resp_mux_n;

  localparam int DW = 32;
  localparam int N  = 4;
  localparam int CW = 2;

  logic            HCLK;
  logic            HRESETn;
  logic [N-1:0]    HSEL;
  logic [1:0]      HTRANS;
  logic [N-1:0]    HREADYOUT_S;
  logic [2*N-1:0]  HRESP_S;
  logic [N*DW-1:0] HRDATA_S;
  logic [DW-1:0]   HRDATA;
  logic [1:0]      HRESP;
  logic            HREADY;
  logic            dec_err;
  logic [CW-1:0]   dec_err_cnt;

  int checks = 0;
  int errors = 0;

  ahb_resp_mux_n #(
    .DATA_WIDTH(DW), .NO_OF_SUBORDINATES(N), .ERR_CNT_WIDTH(CW)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HTRANS(HTRANS),
    .HREADYOUT_S(HREADYOUT_S), .HRESP_S(HRESP_S), .HRDATA_S(HRDATA_S),
    .HRDATA(HRDATA), .HRESP(HRESP), .HREADY(HREADY),
    .dec_err(dec_err), .dec_err_cnt(dec_err_cnt)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic tick;
    @(posedge HCLK);
    #1;
  endtask

  task automatic test_reset;
    HRESETn = 1'b0; HSEL = 4'b0000; HTRANS = 2'b00;
    HREADYOUT_S = 4'b1111; HRESP_S = 8'h00; HRDATA_S = '0;
    #3;
    checks++; if (HREADY !== 1'b1) begin errors++; $display("FAIL reset_hready got %b exp 1", HREADY); end
    checks++; if (HRESP !== 2'b00) begin errors++; $display("FAIL reset_hresp got %b exp 00", HRESP); end
    checks++; if (HRDATA !== 32'h0) begin errors++; $display("FAIL reset_hrdata got %h exp 0", HRDATA); end
    checks++; if (dec_err_cnt !== 2'd0 || dec_err !== 1'b0) begin errors++; $display("FAIL reset_cnt got %0d/%b exp 0/0", dec_err_cnt, dec_err); end
    @(negedge HCLK);
    HRESETn = 1'b1;
  endtask

  task automatic test_read;
    HRDATA_S[1*DW +: DW] = 32'hA5A5_0001;
    HSEL = 4'b0010; HTRANS = 2'b10;
    tick;
    HSEL = 4'b1000; HTRANS = 2'b10; HRDATA_S[3*DW +: DW] = 32'h3333_0003; HRESP_S[7:6] = 2'b01;
    #1;
    checks++; if (HRDATA !== 32'hA5A5_0001) begin errors++; $display("FAIL read_data got %h exp a5a50001", HRDATA); end
    checks++; if (HRESP !== 2'b00 || HREADY !== 1'b1) begin errors++; $display("FAIL read_resp got %b/%b exp 00/1", HRESP, HREADY); end
    tick;
    HSEL = 4'b0000; HTRANS = 2'b00;
    #1;
    checks++; if (HRDATA !== 32'h3333_0003 || HRESP !== 2'b01) begin errors++; $display("FAIL sub3_route got %h/%b exp 33330003/01", HRDATA, HRESP); end
    tick;
    HRESP_S[7:6] = 2'b00;
    #1;
    checks++; if (HRDATA !== 32'h0 || HRESP !== 2'b00 || HREADY !== 1'b1) begin errors++; $display("FAIL none_owner got %h/%b/%b exp 0/00/1", HRDATA, HRESP, HREADY); end
  endtask

  task automatic test_wait_states;
    HRDATA_S[2*DW +: DW] = 32'h2222_0002;
    HRDATA_S[0*DW +: DW] = 32'h0000_00C0;
    HSEL = 4'b0100; HTRANS = 2'b10;
    tick;
    HREADYOUT_S[2] = 1'b0; HSEL = 4'b0001; HTRANS = 2'b10;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (HREADY !== 1'b0 || HRDATA !== 32'h2222_0002) begin errors++; $display("FAIL wait_cycle%0d got %b/%h exp 0/22220002", c, HREADY, HRDATA); end
      tick;
    end
    HREADYOUT_S[2] = 1'b1;
    #1;
    checks++; if (HREADY !== 1'b1 || HRDATA !== 32'h2222_0002) begin errors++; $display("FAIL wait_release got %b/%h exp 1/22220002", HREADY, HRDATA); end
    tick;
    HSEL = 4'b0000; HTRANS = 2'b00;
    #1;
    checks++; if (HRDATA !== 32'h0000_00C0) begin errors++; $display("FAIL wait_next_accept got %h exp 000000c0", HRDATA); end
    tick;
  endtask

  // One decode error from a settled IDLE bus; ends back in IDLE.
  task automatic do_error(input logic [3:0] sel, input logic [1:0] trans, input int exp_cnt, input string nm);
    HSEL = sel; HTRANS = trans;
    tick;
    HSEL = 4'b0000; HTRANS = 2'b00;
    #1;
    checks++; if (HREADY !== 1'b0 || HRESP !== 2'b01 || dec_err !== 1'b1 || HRDATA !== 32'h0) begin errors++; $display("FAIL %s_err1 got %b/%b/%b/%h exp 0/01/1/0", nm, HREADY, HRESP, dec_err, HRDATA); end
    tick;
    checks++; if (HREADY !== 1'b1 || HRESP !== 2'b01 || dec_err !== 1'b0) begin errors++; $display("FAIL %s_err2 got %b/%b/%b exp 1/01/0", nm, HREADY, HRESP, dec_err); end
    tick;
    checks++; if (HREADY !== 1'b1 || HRESP !== 2'b00 || dec_err_cnt !== CW'(exp_cnt)) begin errors++; $display("FAIL %s_after got %b/%b/%0d exp 1/00/%0d", nm, HREADY, HRESP, dec_err_cnt, exp_cnt); end
  endtask

  task automatic test_decode_errors;
    do_error(4'b0000, 2'b10, 1, "unmapped");
    do_error(4'b0110, 2'b11, 2, "multihot");
  endtask

  task automatic test_idle;
    HSEL = 4'b0000; HTRANS = 2'b00;
    tick;
    checks++; if (HREADY !== 1'b1 || HRESP !== 2'b00 || dec_err !== 1'b0 || dec_err_cnt !== 2'd2) begin errors++; $display("FAIL idle got %b/%b/%b/%0d exp 1/00/0/2", HREADY, HRESP, dec_err, dec_err_cnt); end
    HSEL = 4'b0110; HTRANS = 2'b01;
    tick;
    checks++; if (HREADY !== 1'b1 || HRESP !== 2'b00 || dec_err_cnt !== 2'd2) begin errors++; $display("FAIL busy_multihot got %b/%b/%0d exp 1/00/2", HREADY, HRESP, dec_err_cnt); end
    HSEL = 4'b0000; HTRANS = 2'b00;
    tick;
  endtask

  task automatic test_back_to_back;
    HSEL = 4'b0000; HTRANS = 2'b10;
    tick;
    checks++; if (dec_err !== 1'b1 || HREADY !== 1'b0 || dec_err_cnt !== 2'd3) begin errors++; $display("FAIL b2b_first got %b/%b/%0d exp 1/0/3", dec_err, HREADY, dec_err_cnt); end
    tick;
    checks++; if (dec_err !== 1'b0 || HREADY !== 1'b1 || HRESP !== 2'b01) begin errors++; $display("FAIL b2b_err2 got %b/%b/%b exp 0/1/01", dec_err, HREADY, HRESP); end
    tick;
    checks++; if (dec_err !== 1'b1 || HREADY !== 1'b0 || HRESP !== 2'b01) begin errors++; $display("FAIL b2b_second got %b/%b/%b exp 1/0/01", dec_err, HREADY, HRESP); end
    HTRANS = 2'b00;
    tick;
    tick;
    checks++; if (dec_err_cnt !== 2'd3 || HRESP !== 2'b00) begin errors++; $display("FAIL b2b_sat got %0d/%b exp 3/00", dec_err_cnt, HRESP); end
  endtask

  task automatic test_reset_in_err1;
    HSEL = 4'b0000; HTRANS = 2'b10;
    tick;
    HTRANS = 2'b00;
    checks++; if (HREADY !== 1'b0 || dec_err_cnt !== 2'd3) begin errors++; $display("FAIL fifth_err got %b/%0d exp 0/3", HREADY, dec_err_cnt); end
    HRESETn = 1'b0;
    #1;
    checks++; if (HREADY !== 1'b1 || HRESP !== 2'b00 || dec_err !== 1'b0 || dec_err_cnt !== 2'd0) begin errors++; $display("FAIL async_reset got %b/%b/%b/%0d exp 1/00/0/0", HREADY, HRESP, dec_err, dec_err_cnt); end
    @(negedge HCLK);
    HRESETn = 1'b1;
    tick;
    checks++; if (HREADY !== 1'b1 || HRESP !== 2'b00) begin errors++; $display("FAIL post_reset got %b/%b exp 1/00", HREADY, HRESP); end
  endtask

  initial begin
    test_reset;
    test_read;
    test_wait_states;
    test_decode_errors;
    test_idle;
    test_back_to_back;
    test_reset_in_err1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_resp_mux_n.md
# ahb_resp_mux_n

Parametrised AHB-Lite data-phase response multiplexer for an N-subordinate interconnect. It sits between the subordinates and the single manager. It tracks which subordinate owns the current data phase and routes that subordinate's HRDATA/HRESP/HREADYOUT back to the manager. It contains a built-in default subordinate that answers unmapped or multiply-decoded transfers with a two-cycle ERROR response, and it keeps a saturating decode-error counter.

## Interface
- DATA_WIDTH, 32, width of read data bus
- NO_OF_SUBORDINATES, 4, number of subordinates N (1..16)
- ERR_CNT_WIDTH, 8, width of decode-error counter
- HCLK  input  1  bus clock
- HRESETn  input  1  reset: asynchronous, active-low
- HSEL  input  N  address-phase select vector from decoder, bit i = subordinate i
- HTRANS  input  2  address-phase transfer type from manager
- HREADYOUT_S  input  N  per-subordinate ready, bit i
- HRESP_S  input  2N  per-subordinate response, bits [2i+1:2i]
- HRDATA_S  input  N*DATA_WIDTH  per-subordinate read data, slice i
- HRDATA  output  DATA_WIDTH  muxed read data to manager
- HRESP  output  2  muxed response (00 OKAY, 01 ERROR)
- HREADY  output  1  muxed ready; also fed back to all subordinates as HREADY
- dec_err  output  1  one-cycle pulse when a decode error enters ERR1
- dec_err_cnt  output  ERR_CNT_WIDTH  saturating count of decode errors

## Operation
- Address phase is accepted on a rising HCLK edge where HREADY (the muxed output) = 1; nothing is sampled when HREADY = 0.
- Decode on acceptance:
  - HSEL one-hot: data_sel <= that index, owner = subordinate. Applies regardless of HTRANS.
  - HSEL zero or multi-hot with HTRANS[1] = 0 (IDLE/BUSY): owner = NONE.
  - HSEL zero or multi-hot with HTRANS[1] = 1 (NONSEQ/SEQ): owner = DEFAULT, decode error.
- Owner = subordinate i: HRDATA = slice i, HRESP = HRESP_S[i], HREADY = HREADYOUT_S[i].
- Owner = NONE: HRDATA = 0, HRESP = OKAY, HREADY = 1.
- Default subordinate FSM with states IDLE, ERR1, ERR2:
  - IDLE -> ERR1 on a decode error accepted.
  - ERR1 drives HREADY = 0, HRESP = ERROR, HRDATA = 0; always -> ERR2.
  - ERR2 drives HREADY = 1, HRESP = ERROR, HRDATA = 0.
  - ERR2 accepts the next address phase: -> ERR1 if it is another decode error, else -> IDLE with the new owner.
- Owner register and FSM hold their value while HREADY = 0. HSEL/HTRANS changes during a wait state are ignored.
- Counter: dec_err_cnt += 1 on each ERR1 entry; saturates at all-ones, with no wrap.

## Timing
- Reset values: owner = NONE, FSM = IDLE, HRDATA = 0, HRESP = OKAY, HREADY = 1, dec_err = 0, dec_err_cnt = 0.
- Address phase accepted at edge k → data phase is routed combinationally from the selected subordinate during cycle k+1. There is no extra pipeline stage on data.
- Output paths are combinational from HREADYOUT_S/HRESP_S/HRDATA_S through the owner mux. No loop: owner is a register.
- dec_err is high for exactly the ERR1 cycle.
- Back-to-back decode errors give the pattern ERR1, ERR2, ERR1, ERR2, one counter increment each.
- A subordinate wait state (HREADYOUT_S[i] = 0) stretches the data phase. The next address is accepted only on the edge where it returns to 1.
- Reset asserted mid-transfer (including in ERR1): all state clears immediately (asynchronous). Outputs return to reset values without waiting for an edge.

## Structure
- Shared package ahb_pkg holds:
  - HTRANS encodings IDLE = 00, BUSY = 01, NONSEQ = 10, SEQ = 11.
  - HRESP encodings OKAY = 00, ERROR = 01.
  - Default-subordinate FSM state enum.
- One sub-module, ahb_default_sub: the ERR FSM plus the dec_err pulse, with a hit input and HREADY/HRESP outputs.
- The top level holds the one-hot check, the owner register, the mux and the counter.

## Test plan
- Reset → HREADY = 1, HRESP = 00, HRDATA = 0, dec_err_cnt = 0.
- Read: HSEL = 0010, HTRANS = NONSEQ, HRDATA_S slice1 = 0xA5A5_0001 → next cycle HRDATA = 0xA5A5_0001, HRESP = 00.
- Wait states: subordinate 2 holds HREADYOUT low for 3 cycles.
  - HREADY is low for the same 3 cycles.
  - HSEL toggled to 0001 during the wait is ignored; it is accepted only on the release edge.
- Decode errors: HSEL = 0000 with NONSEQ → HREADY 0 then 1, HRESP 01 for both cycles, dec_err pulses once, count = 1. HSEL = 0110 with SEQ behaves the same.
- IDLE: HSEL = 0000 with HTRANS = IDLE → OKAY with zero wait, no count.
- Counter and reset: with ERR_CNT_WIDTH = 2, five errors → dec_err_cnt = 3. Reset asserted during ERR1 → HREADY = 1 and HRESP = 00 immediately.
